// File: rtl/ntt_pu_sequencer.sv
// ntt_pu_sequencer: steps one NTT/INTT processing unit through whole
// transforms, with a one-entry input buffer and a registered result slot.
module ntt_pu_sequencer #(
  parameter int N = 17,
  parameter int D = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [D*N-1:0]         in_data,
  input  logic                   in_inv,
  output logic [D*N-1:0]         pu_a,
  output logic                   pu_load,
  output logic                   pu_en,
  output logic                   pu_inv,
  output logic [$clog2($clog2(D))-1:0] pu_stage,
  input  logic [D*N-1:0]         pu_an,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D*N-1:0]         out_data,
  output logic                   out_inv,
  output logic                   busy
);

  localparam int S  = $clog2(D);
  localparam int SW = $clog2(S);
  localparam logic [SW-1:0] LAST_F = SW'(S - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    STALL
  } state_e;

  state_e           state_q, state_d;
  logic             buf_full_q, buf_full_d;
  logic [D*N-1:0]   buf_data_q, buf_data_d;
  logic             buf_inv_q, buf_inv_d;
  logic             cur_inv_q, cur_inv_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [D*N-1:0]   out_data_q, out_data_d;
  logic             out_inv_q, out_inv_d;

  logic push;
  logic last;
  logic slot_free;
  logic capture;

  assign in_ready  = !buf_full_q || (state_q == LOAD);
  assign push      = in_valid && in_ready;
  assign slot_free = !out_valid_q || out_ready;
  // Last stage is an explicit compare so the counter never wraps.
  assign last      = cur_inv_q ? (cnt_q == '0) : (cnt_q == LAST_F);

  assign pu_a      = buf_data_q;
  assign pu_stage  = cnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_inv   = out_inv_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    buf_full_d  = buf_full_q;
    buf_data_d  = buf_data_q;
    buf_inv_d   = buf_inv_q;
    cur_inv_d   = cur_inv_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_inv_d   = out_inv_q;
    pu_load     = 1'b0;
    pu_en       = 1'b0;
    pu_inv      = cur_inv_q;
    capture     = 1'b0;

    if (push) begin
      buf_full_d = 1'b1;
      buf_data_d = in_data;
      buf_inv_d  = in_inv;
    end

    unique case (state_q)
      IDLE: begin
        if (buf_full_q) state_d = LOAD;
      end
      LOAD: begin
        pu_load   = 1'b1;
        pu_en     = 1'b1;
        pu_inv    = buf_inv_q;
        cur_inv_d = buf_inv_q;
        cnt_d     = buf_inv_q ? LAST_F : '0;
        state_d   = RUN;
        if (!push) buf_full_d = 1'b0;
      end
      RUN: begin
        pu_en = 1'b1;
        if (!last) begin
          cnt_d = cur_inv_q ? cnt_q - SW'(1)
                            : cnt_q + SW'(1);
        end else if (slot_free) begin
          capture = 1'b1;
        end else begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (slot_free) capture = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // A capture in the same cycle as a drain wins.
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = pu_an;
      out_inv_d   = cur_inv_q;
      state_d     = buf_full_d ? LOAD : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      buf_full_q  <= 1'b0;
      buf_data_q  <= '0;
      buf_inv_q   <= 1'b0;
      cur_inv_q   <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_inv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_full_q  <= buf_full_d;
      buf_data_q  <= buf_data_d;
      buf_inv_q   <= buf_inv_d;
      cur_inv_q   <= cur_inv_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_inv_q   <= out_inv_d;
    end
  end

endmodule

// File: tb/tb_ntt_pu_sequencer.sv
// Directed bench for ntt_pu_sequencer with a toy PU that adds a
// stage/direction-dependent offset to every coefficient per enabled cycle.
module tb_ntt_pu_sequencer;

  localparam int N  = 17;
  localparam int D  = 16;
  localparam int SW = 2;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [D*N-1:0] in_data;
  logic           in_inv;
  logic [D*N-1:0] pu_a;
  logic           pu_load;
  logic           pu_en;
  logic           pu_inv;
  logic [SW-1:0]  pu_stage;
  logic [D*N-1:0] pu_an;
  logic           out_valid;
  logic           out_ready;
  logic [D*N-1:0] out_data;
  logic           out_inv;
  logic           busy;

  int n_chk = 0;
  int n_bad = 0;

  ntt_pu_sequencer #(.N(N), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .pu_a      (pu_a),
    .pu_load   (pu_load),
    .pu_en     (pu_en),
    .pu_inv    (pu_inv),
    .pu_stage  (pu_stage),
    .pu_an     (pu_an),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_inv   (out_inv),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy PU: stage s adds s+1 (+16 when inverse) to each coefficient.
  // Four forward stages add 10 in total, four inverse stages add 74.
  logic [D*N-1:0] pu_reg;

  always_ff @(posedge clk) begin
    if (pu_load)    pu_reg <= pu_a;
    else if (pu_en) pu_reg <= pu_an;
  end

  always_comb begin
    pu_an = '0;
    for (int i = 0; i < D; i++) begin
      pu_an[i*N +: N] = pu_reg[i*N +: N]
        + N'(32'(pu_stage) + 1 + (pu_inv ? 16 : 0));
    end
  end

  function automatic logic [D*N-1:0] vec(input int base);
    logic [D*N-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) v[i*N +: N] = N'(base + i);
    return v;
  endfunction

  task automatic check(input string tag,
                       input logic [D*N-1:0] got,
                       input logic [D*N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input int base, input logic inv);
    in_valid = 1'b1;
    in_data  = vec(base);
    in_inv   = inv;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_inv    = 1'b0;
    out_ready = 1'b1;

    // reset
    tick;
    tick;
    rst = 1'b1;
    check("rst_oval", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_en", pu_en, 0);
    check("rst_load", pu_load, 0);
    check("rst_odata", out_data, 0);
    check("rst_oinv", out_inv, 0);
    tick;
    check("idle_busy", busy, 0);

    // forward, vector 0..15
    push_vec(0, 1'b0);
    tick;
    in_valid = 1'b0;
    check("f_c1_ready", in_ready, 0);
    check("f_c1_busy", busy, 0);
    tick;
    check("f_load", pu_load, 1);
    check("f_load_en", pu_en, 1);
    check("f_load_inv", pu_inv, 0);
    check("f_pu_a", pu_a, vec(0));
    for (int c = 0; c < 4; c++) begin
      tick;
      check("f_stage", pu_stage, c);
      check("f_inv", pu_inv, 0);
      check("f_en", pu_en, 1);
      check("f_noload", pu_load, 0);
      check("f_oval0", out_valid, 0);
    end
    tick;
    check("f_oval", out_valid, 1);
    check("f_odata", out_data, vec(10));
    check("f_oinv", out_inv, 0);
    check("f_idle", busy, 0);
    tick;
    check("f_drain", out_valid, 0);

    // inverse, vector 100..115
    push_vec(100, 1'b1);
    tick;
    in_valid = 1'b0;
    tick;
    check("i_load", pu_load, 1);
    check("i_load_inv", pu_inv, 1);
    for (int c = 0; c < 4; c++) begin
      tick;
      check("i_stage", pu_stage, 3 - c);
      check("i_inv", pu_inv, 1);
      check("i_en", pu_en, 1);
    end
    tick;
    check("i_oval", out_valid, 1);
    check("i_odata", out_data, vec(174));
    check("i_oinv", out_inv, 1);
    tick;
    check("i_drain", out_valid, 0);

    // back-to-back: A forward, B inverse pushed during A's RUN
    push_vec(200, 1'b0);
    tick;
    in_valid = 1'b0;
    tick;
    check("bb_a_load", pu_load, 1);
    check("bb_load_ready", in_ready, 1);
    tick;
    check("bb_run_ready", in_ready, 1);
    push_vec(300, 1'b1);
    tick;
    in_valid = 1'b0;
    check("bb_full_ready", in_ready, 0);
    check("bb_pu_a", pu_a, vec(300));
    check("bb_a_inv", pu_inv, 0);
    check("bb_a_stage", pu_stage, 1);
    tick;
    tick;
    check("bb_a_last", pu_stage, 3);
    tick;
    check("bb_a_oval", out_valid, 1);
    check("bb_a_odata", out_data, vec(210));
    check("bb_a_oinv", out_inv, 0);
    check("bb_b_load", pu_load, 1);
    check("bb_b_linv", pu_inv, 1);
    tick;
    check("bb_b_st0", pu_stage, 3);
    check("bb_gap", out_valid, 0);
    repeat (3) tick;
    check("bb_b_last", pu_stage, 0);
    check("bb_b_oval0", out_valid, 0);
    tick;
    check("bb_b_oval", out_valid, 1);
    check("bb_b_odata", out_data, vec(374));
    check("bb_b_oinv", out_inv, 1);
    check("bb_idle", busy, 0);
    tick;
    check("bb_drain", out_valid, 0);

    // backpressure: A held in the slot, B stalls on its last stage
    out_ready = 1'b0;
    push_vec(400, 1'b0);
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    push_vec(500, 1'b0);
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    tick;
    check("bp_a_oval", out_valid, 1);
    check("bp_a_odata", out_data, vec(410));
    check("bp_b_load", pu_load, 1);
    repeat (4) tick;
    check("bp_b_last", pu_stage, 3);
    check("bp_b_en", pu_en, 1);
    tick;
    check("bp_st_busy", busy, 1);
    check("bp_st_en", pu_en, 0);
    check("bp_st_stage", pu_stage, 3);
    check("bp_st_hold", out_data, vec(410));
    tick;
    check("bp_st_en2", pu_en, 0);
    check("bp_st_hold2", out_data, vec(410));
    check("bp_st_oval", out_valid, 1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    // PU register froze at B+10 so the stalled output is B+14.
    check("bp_b_oval", out_valid, 1);
    check("bp_b_odata", out_data, vec(514));
    check("bp_b_idle", busy, 0);
    tick;
    check("bp_b_hold", out_data, vec(514));
    check("bp_b_oval2", out_valid, 1);

    // reset mid-RUN with a second vector buffered
    out_ready = 1'b1;
    push_vec(600, 1'b0);
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    push_vec(700, 1'b0);
    tick;
    in_valid = 1'b0;
    check("mr_stage", pu_stage, 1);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    check("mr_busy", busy, 0);
    check("mr_oval", out_valid, 0);
    check("mr_ready", in_ready, 1);
    check("mr_en", pu_en, 0);
    check("mr_odata", out_data, 0);
    tick;
    check("mr_noload", pu_load, 0);
    check("mr_idle", busy, 0);
    repeat (6) tick;
    check("mr_nocap", out_valid, 0);
    check("mr_idle2", busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ntt_pu_sequencer.md
Name: ntt_pu_sequencer

Overview:
Sequences one NTT/INTT processing unit (PU) through whole transforms.
- Accepts a D-coefficient vector plus a direction flag over a valid/ready handshake, with a one-entry input buffer.
- Drives the PU's load, stage, direction and clock-enable controls through log2(D) butterfly stages.
- Captures the PU result into an output register and presents it over a valid/ready handshake.
- Sits between the system stream interface and the PU; the PU itself is unchanged.

Parameters:
N, 17, coefficient width in bits
D, 16, coefficients per vector (power of two, >=4)
S, $clog2(D), number of butterfly stages (derived; never overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
in_valid  input  1  input vector valid
in_ready  output  1  input buffer can accept this cycle
in_data  input  D*N  input coefficient vector
in_inv  input  1  0 = forward NTT, 1 = inverse NTT
pu_a  output  D*N  vector presented to PU load port (buffer contents)
pu_load  output  1  PU register captures pu_a this cycle
pu_en  output  1  PU register clock-enable
pu_inv  output  1  PU direction for current transform
pu_stage  output  $clog2(S)  current stage index to PU
pu_an  input  D*N  PU result vector (combinational from PU)
out_valid  output  1  result vector valid
out_ready  input  1  downstream accepts result
out_data  output  D*N  captured result vector
out_inv  output  1  direction of the transform that produced out_data
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE; buffer empty; out_valid=0; out_data=0; out_inv=0; stage counter=0.
  - pu_load=0, pu_en=0.
  - Applies mid-transform too: the transform in flight and any buffered vector are discarded, with no capture.
- Input buffer:
  - in_ready = !buf_full || (state==LOAD). The buffer pops at the end of LOAD, so a push in the same cycle is legal.
  - A push on in_valid&&in_ready latches in_data and in_inv.
  - pu_a always equals the buffer data; it is stable while buf_full.
- FSM states: IDLE, LOAD, RUN, STALL.
  - IDLE: pu_en=0. If buf_full, go to LOAD.
  - LOAD (1 cycle):
    - pu_load=1, pu_en=1, pu_inv=buf_inv.
    - Latch cur_inv=buf_inv; pop buffer.
    - Stage counter := 0 if forward, S-1 if inverse. Go to RUN.
  - RUN:
    - pu_en=1, pu_inv=cur_inv, pu_stage=counter.
    - Counter advances +1 (forward) or -1 (inverse) each cycle.
    - Last stage is S-1 for forward, 0 for inverse.
    - In the last-stage cycle, if the output slot is free (out_valid==0 || out_ready):
      - Capture pu_an into out_data and cur_inv into out_inv; set out_valid=1.
      - Next state is LOAD if buf_full after this cycle's push, else IDLE.
    - If the slot is not free, go to STALL and hold the counter.
  - STALL:
    - pu_en=0; pu_stage held at the last stage; PU state frozen.
    - When the slot frees, capture pu_an and leave as from RUN.
- Output handshake:
  - out_valid clears on out_valid&&out_ready unless a new capture happens in the same cycle.
  - out_data and out_inv are stable while out_valid && !out_ready.
- Latency (accept edge = edge 0): LOAD in cycle 2, RUN in cycles 3..S+2, out_valid in cycle S+3. For D=16 that is cycle 7.
- Throughput: one transform per S+1 cycles when the buffer is kept full and out_ready=1.
- Direction: pu_inv is constant from LOAD through capture and cannot change mid-transform.
- Arithmetic: the counter is exactly $clog2(S) bits and never wraps. Transitions at the last stage are explicit, not derived from wrap-around.

Test Plan:
1. Reset: rst=0 for 2 cycles, then 1 -> out_valid=0, in_ready=1, busy=0, pu_en=0, pu_load=0.
2. Forward, D=16: accept vector 0..15 with in_inv=0 at edge 0 -> pu_load=1 in cycle 2; pu_stage=0,1,2,3 in cycles 3-6; out_valid=1 in cycle 7; out_data = pu_an sampled in cycle 6; out_inv=0.
3. Inverse: in_inv=1 -> pu_stage=3,2,1,0 in cycles 3-6; pu_inv=1 from cycle 2 to cycle 6; out_inv=1.
4. Back-to-back: push A, then push B during A's RUN with out_ready=1 -> in_ready=0 while B is buffered; B's LOAD immediately follows A's last stage; out_valid pulses for A at cycle 7 and for B at cycle 12.
5. Backpressure: out_ready=0, push A and B -> A is held on out_data; B reaches STALL with pu_en=0 and pu_stage=3. Pulse out_ready for 1 cycle -> B is captured on that cycle and out_data changes exactly once.
6. Reset mid-RUN: rst=0 in cycle 4 of a forward transform -> next cycle IDLE, buffer empty, out_valid=0, no capture.
